// File: rtl/path_replayer.sv
// path_replayer: replays 2-bit move codes from the maze solver into absolute
// X/Y positions on a 16x16 grid. A small FIFO decouples the move source from
// the position consumer; wall-wrap and path completion are flagged as levels.
// Optional build macro: PATH_REPLAY_GOAL_CHECK_EN (the final move must land
// on (15,15), otherwise the path ends in error instead of done).
module path_replayer #(
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic          cl,
    input  logic          rst,
    input  logic          start,
    input  logic          mv_valid,
    input  logic [1:0]    mv_data,
    input  logic          mv_last,
    output logic          mv_ready,
    output logic          pos_valid,
    input  logic          pos_ready,
    output logic [3:0]    x_out,
    output logic [3:0]    y_out,
    output logic [CW-1:0] steps,
    output logic          done,
    output logic          err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERR} state_t;

    state_t state_reg, state_next;

    // FIFO entries hold {last, code}
    logic [2:0]       fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic [3:0]    x_reg, y_reg;
    logic [CW-1:0] steps_reg;
    logic          pos_valid_reg, done_reg, err_reg;

    logic       push, pop;
    logic       head_last;
    logic [1:0] head_code;
    logic [4:0] x_next5, y_next5;
    logic       wrap, goal_miss;

    assign head_last = fifo_mem[rd_ptr_reg][2];
    assign head_code = fifo_mem[rd_ptr_reg][1:0];

    // Ready depends only on registered state and count, never on the pop
    assign mv_ready = (state_reg == S_RUN) && (count_reg != FULL_CNT);
    assign push     = mv_valid && mv_ready;
    assign pop      = (state_reg == S_RUN) && (count_reg != '0) &&
                      (!pos_valid_reg || pos_ready);

    // Candidate coordinate for the head move; bit 4 flags leaving the grid
    always_comb begin
        x_next5 = {1'b0, x_reg};
        y_next5 = {1'b0, y_reg};
        case (head_code)
            2'b00:   y_next5 = {1'b0, y_reg} - 5'd1;
            2'b01:   x_next5 = {1'b0, x_reg} + 5'd1;
            2'b10:   x_next5 = {1'b0, x_reg} - 5'd1;
            default: y_next5 = {1'b0, y_reg} + 5'd1;
        endcase
    end

    assign wrap = x_next5[4] | y_next5[4];

`ifdef PATH_REPLAY_GOAL_CHECK_EN
    assign goal_miss = head_last && ({x_next5[3:0], y_next5[3:0]} != 8'hFF);
`else
    assign goal_miss = 1'b0;
`endif

    // FIFO storage: one register per entry, written when the write pointer selects it
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fifo
            // Capture the incoming move into this slot
            always_ff @(posedge cl) begin
                if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    fifo_mem[gi] <= {mv_last, mv_data};
                end
            end
        end
    endgenerate

    // State register
    always_ff @(posedge cl) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: start restarts from any state; an applied move may terminate the path
    always_comb begin
        state_next = state_reg;
        if (start) begin
            state_next = S_RUN;
        end else if (state_reg == S_RUN && pop) begin
            if (wrap || goal_miss) begin
                state_next = S_ERR;
            end else if (head_last) begin
                state_next = S_DONE;
            end
        end
    end

    // Datapath: FIFO pointers, coordinates, output handshake, counters and flags
    always_ff @(posedge cl) begin
        if (rst || start) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            x_reg         <= '0;
            y_reg         <= '0;
            steps_reg     <= '0;
            pos_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            if (pos_valid_reg && pos_ready) begin
                pos_valid_reg <= 1'b0;
            end
            if (pop && wrap) begin
                // Leaving the grid: keep coordinates, drop everything queued
                err_reg    <= 1'b1;
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (pop) begin
                    x_reg         <= x_next5[3:0];
                    y_reg         <= y_next5[3:0];
                    pos_valid_reg <= 1'b1;
                    if (steps_reg != '1) begin
                        steps_reg <= steps_reg + 1'b1;
                    end
                    if (goal_miss) begin
                        err_reg <= 1'b1;
                    end else if (head_last) begin
                        done_reg <= 1'b1;
                    end
                end
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count_reg <= count_reg + 1'b1;
                    2'b01:   count_reg <= count_reg - 1'b1;
                    default: count_reg <= count_reg;
                endcase
            end
        end
    end

    assign pos_valid = pos_valid_reg;
    assign x_out     = x_reg;
    assign y_out     = y_reg;
    assign steps     = steps_reg;
    assign done      = done_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_path_replayer.sv
// tb_path_replayer: randomized scoreboard bench for path_replayer. A grid
// model computes expected positions as moves are accepted; a monitor pops
// and compares on every position handshake.
module tb_path_replayer;

    localparam int DEPTH = 4;
    localparam int CW    = 8;

    logic          cl = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          mv_valid = 1'b0;
    logic [1:0]    mv_data = 2'b00;
    logic          mv_last = 1'b0;
    logic          mv_ready;
    logic          pos_valid;
    logic          pos_ready = 1'b0;
    logic [3:0]    x_out, y_out;
    logic [CW-1:0] steps;
    logic          done, err;

    path_replayer #(.DEPTH(DEPTH), .CW(CW)) dut (
        .cl(cl), .rst(rst), .start(start),
        .mv_valid(mv_valid), .mv_data(mv_data), .mv_last(mv_last), .mv_ready(mv_ready),
        .pos_valid(pos_valid), .pos_ready(pos_ready),
        .x_out(x_out), .y_out(y_out), .steps(steps), .done(done), .err(err)
    );

    always #5 cl = ~cl;

    int n_cmp = 0;
    int n_bad = 0;

    // scoreboard of expected {x,y}
    logic [7:0] exp_q[$];
    bit mon_en = 0;
    bit rand_ready = 0;

    // reference model state
    int mx, my, msteps;
    bit mdone, merr;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge cl);
        #1;
    endtask

    // Grid model: a move either stays on the 16x16 grid or ends the path in error
    task automatic model_move(input logic [1:0] c, input bit l);
        int nx, ny;
        nx = mx;
        ny = my;
        case (c)
            2'd0: ny = ny - 1;
            2'd1: nx = nx + 1;
            2'd2: nx = nx - 1;
            default: ny = ny + 1;
        endcase
        if (nx < 0 || nx > 15 || ny < 0 || ny > 15) begin
            merr = 1;
        end else begin
            mx = nx;
            my = ny;
            if (msteps < 255) msteps++;
            exp_q.push_back({4'(nx), 4'(ny)});
            if (l) begin
`ifdef PATH_REPLAY_GOAL_CHECK_EN
                if (nx != 15 || ny != 15) merr = 1;
                else mdone = 1;
`else
                mdone = 1;
`endif
            end
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        mx = 0; my = 0; msteps = 0; mdone = 0; merr = 0;
        exp_q.delete();
    endtask

    // Offer one move and hold it until accepted (bounded)
    task automatic send(input logic [1:0] c, input bit l);
        bit acc;
        acc = 0;
        mv_valid = 1'b1;
        mv_data  = c;
        mv_last  = l;
        for (int i = 0; i < 300; i++) begin
            @(negedge cl);
            if (mv_ready) begin
                acc = 1;
                model_move(c, l);
            end
            tick();
            if (acc) break;
        end
        mv_valid = 1'b0;
        mv_last  = 1'b0;
        if (!acc) chk("mv_accept_timeout", 0, 1);
    endtask

    task automatic end_checks(input string tag);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 400) begin
            tick();
            i++;
        end
        chk({tag, "_drain"}, exp_q.size(), 0);
        repeat (3) tick();
        chk({tag, "_done"}, done, int'(mdone));
        chk({tag, "_err"}, err, int'(merr));
        chk({tag, "_steps"}, steps, msteps);
        chk({tag, "_x"}, x_out, mx);
        chk({tag, "_y"}, y_out, my);
        chk({tag, "_mv_ready"}, mv_ready, 0);
    endtask

    // Random consumer backpressure
    always @(posedge cl) begin
        #1;
        if (rand_ready) pos_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: hold stability and scoreboard comparison on each handshake
    bit         held = 0;
    logic [7:0] held_xy;
    logic [7:0] mon_e;
    always @(negedge cl) begin
        if (mon_en) begin
            if (held) begin
                chk("hold_valid", pos_valid, 1);
                chk("hold_xy", {x_out, y_out}, held_xy);
            end
            held    = pos_valid && !pos_ready && !start && !rst;
            held_xy = {x_out, y_out};
            if (pos_valid && pos_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_pos_valid", pos_valid, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pos_xy", {x_out, y_out}, mon_e);
                    $display("pos (%0d,%0d) expected (%0d,%0d) steps=%0d done=%0d",
                             x_out, y_out, mon_e[7:4], mon_e[3:0], steps, done);
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, hs, len;
        logic [1:0] c;
        int r;

        // reset
        tick();
        tick();
        chk("rst_mv_ready", mv_ready, 0);
        chk("rst_pos_valid", pos_valid, 0);
        chk("rst_x", x_out, 0);
        chk("rst_y", y_out, 0);
        chk("rst_steps", steps, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        mv_valid = 1'b1;
        mv_data = 2'b01;
        tick();
        chk("idle_mv_ready", mv_ready, 0);
        mv_valid = 1'b0;
        mon_en = 1;

        // start
        do_start();
        chk("start_mv_ready", mv_ready, 1);
        chk("start_xy", {x_out, y_out}, 0);

        // directed path 01,01,11(last)
        pos_ready = 1'b1;
        send(2'b01, 0);
        chk("latency_n1", pos_valid, 0);
        tick();
        chk("latency_n2", pos_valid, 1);
        send(2'b01, 0);
        send(2'b11, 1);
        tick();
        chk("done_with_last_pos", {pos_valid, done}, 3);
        end_checks("directed");

        // wall error at origin
        do_start();
        send(2'b10, 0);
        end_checks("wall");
        chk("wall_no_pos", pos_valid, 0);
        do_start();
        chk("restart_err_clear", err, 0);

        // burst with backpressure
        pos_ready = 1'b0;
        acc = 0;
        mv_valid = 1'b1;
        mv_data = 2'b01;
        mv_last = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge cl);
            if (mv_ready && acc < 6) begin
                acc++;
                model_move(2'b01, 0);
            end
            tick();
        end
        chk("burst_accepted", acc, 5);
        chk("burst_mv_ready_low", mv_ready, 0);
        pos_ready = 1'b1;
        hs = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge cl);
            if (pos_valid && pos_ready) hs++;
            if (mv_valid && mv_ready) begin
                acc++;
                model_move(2'b01, 0);
            end
            tick();
            if (acc >= 6) mv_valid = 1'b0;
        end
        mv_valid = 1'b0;
        chk("burst_throughput", hs, 6);
        send(2'b11, 1);
        end_checks("burst");

        // start mid-stream drops pending output and FIFO
        do_start();
        pos_ready = 1'b0;
        send(2'b01, 0);
        send(2'b11, 0);
        repeat (3) tick();
        chk("mid_pending", pos_valid, 1);
        do_start();
        chk("mid_pos_valid", pos_valid, 0);
        chk("mid_steps", steps, 0);
        chk("mid_xy", {x_out, y_out}, 0);
        pos_ready = 1'b1;
        send(2'b11, 0);
        send(2'b01, 1);
        end_checks("midstart");

        // goal corner and near-miss
        do_start();
        for (int k = 0; k < 15; k++) send(2'b01, 0);
        for (int k = 0; k < 14; k++) send(2'b11, 0);
        send(2'b11, 1);
        end_checks("goal_hit");
        do_start();
        for (int k = 0; k < 14; k++) send(2'b01, 0);
        for (int k = 0; k < 14; k++) send(2'b11, 0);
        send(2'b11, 1);
        end_checks("goal_miss");

        // randomized paths with random backpressure
        rand_ready = 1;
        for (int p = 0; p < 30; p++) begin
            do_start();
            len = $urandom_range(1, 20);
            for (int k = 0; k < len; k++) begin
                r = $urandom_range(0, 9);
                c = (r < 4) ? 2'b01 : (r < 8) ? 2'b11 : (r == 8) ? 2'b10 : 2'b00;
                send(c, k == len - 1);
                if (merr) break;
            end
            end_checks("random");
        end
        rand_ready = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
